// File: rtl/led_fader.sv
// led_fader: event-driven LED brightness envelope (rise / hold / fall).
// Single-cycle trigger strobes start or extend a brightness ramp that advances
// once per prescaler tick. The output bright feeds a downstream pwm block.
// Optional build macro LED_FADER_GAMMA_EN enables square-law brightness mapping;
// without it, bright is the raw level.

module led_fader #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_TICKS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            trigger,
  output logic [BITS-1:0] bright,
  output logic            busy
);

  localparam logic [BITS-1:0] MAX_LEVEL = '1;
  localparam logic [BITS:0]   STEP_EXT  = (BITS+1)'(STEP);
  localparam logic [15:0]     HOLD_INIT = 16'(HOLD_TICKS);

  typedef enum logic [1:0] {
    StIdle,
    StRise,
    StHold,
    StFall
  } state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] level_q, level_d;
  logic [15:0]     hold_q, hold_d;
  logic [BITS-1:0] bright_d;

  // One extra bit so level+STEP cannot wrap before saturation.
  logic [BITS:0]   rise_sum;

  // Next-state, level and hold counter; trigger outranks tick except in RISE.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    hold_d   = hold_q;
    rise_sum = {1'b0, level_q} + STEP_EXT;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StRise;
        end
      end

      StRise: begin
        // Retriggering while rising has nothing to extend, so only tick matters.
        if (tick) begin
          if (rise_sum >= {1'b0, MAX_LEVEL}) begin
            level_d = MAX_LEVEL;
            state_d = StHold;
            hold_d  = HOLD_INIT;
          end else begin
            level_d = rise_sum[BITS-1:0];
          end
        end
      end

      StHold: begin
        if (trigger) begin
          hold_d = HOLD_INIT;
        end else if (tick) begin
          if (hold_q == 16'd0) begin
            state_d = StFall;
          end else begin
            hold_d = hold_q - 16'd1;
          end
        end
      end

      StFall: begin
        if (trigger) begin
          state_d = StRise;
        end else if (tick) begin
          if ({1'b0, level_q} <= STEP_EXT) begin
            level_d = '0;
            state_d = StIdle;
          end else begin
            level_d = level_q - STEP_EXT[BITS-1:0];
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Brightness mapping of the current level, registered below.
`ifdef LED_FADER_GAMMA_EN
  logic [2*BITS-1:0] level_sq;

  // Square-law dimming: keep the upper half of level*level.
  always_comb begin
    level_sq = {{BITS{1'b0}}, level_q} * {{BITS{1'b0}}, level_q};
    bright_d = BITS'(level_sq >> BITS);
  end
`else
  // Linear mapping: bright follows level directly.
  always_comb begin
    bright_d = level_q;
  end
`endif

  // State, level, hold counter and output register with async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      level_q <= '0;
      hold_q  <= 16'd0;
      bright  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      bright  <= bright_d;
    end
  end

  // Decoded straight from the state register, no extra stage.
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_led_fader.sv
// Directed testbench for led_fader with BITS=4, STEP=4, HOLD_TICKS=2.
// Expected brightness is listed as linear levels; with LED_FADER_GAMMA_EN the
// hand-computed square-law table maps them to expected bright values.

module tb_led_fader;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       trigger;
  logic [3:0] bright;
  logic       busy;

  int n_tests;
  int n_fail;

  led_fader #(
    .BITS       (4),
    .STEP       (4),
    .HOLD_TICKS (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .trigger (trigger),
    .bright  (bright),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bright for a given level (hand-computed table for the gamma build).
  function automatic logic [3:0] exp_bright(input int lvl);
`ifdef LED_FADER_GAMMA_EN
    case (lvl)
      0:       return 4'd0;
      3:       return 4'd0;
      4:       return 4'd1;
      7:       return 4'd3;
      8:       return 4'd4;
      11:      return 4'd7;
      12:      return 4'd9;
      15:      return 4'd14;
      default: return 4'hx;
    endcase
`else
    return 4'(lvl);
`endif
  endfunction

  // Apply inputs for one clock, then sample 1 time unit after the edge.
  task automatic run_cycle(input logic trg, input logic tk);
    trigger = trg;
    tick    = tk;
    @(posedge clk);
    #1;
  endtask

  // Bounded drain back to IDLE, then confirm bright returns to zero.
  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    while (busy && cnt < 50) begin
      run_cycle(1'b0, 1'b1);
      cnt++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: busy=%b required 0 after %0d cycles", name, busy, cnt);
    end
    run_cycle(1'b0, 1'b0);
    n_tests++;
    if (bright !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_drain: bright=%0d required 0", name, bright);
    end
  endtask

  task automatic test_reset;
    trigger = 1'b0;
    tick    = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bright !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: bright=%0d busy=%b required 0/0", bright, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle_ticks;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b0, 1'b1);
      n_tests++;
      if (bright !== 4'd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ticks[%0d]: bright=%0d busy=%b required 0/0", i, bright, busy);
      end
    end
  endtask

  task automatic test_single;
    int lv[13] = '{0, 0, 4, 8, 12, 15, 15, 15, 15, 11, 7, 3, 0};
    for (int i = 0; i < 13; i++) begin
      run_cycle(i == 0, 1'b1);
      n_tests++;
      if (bright !== exp_bright(lv[i])) begin
        n_fail++;
        $display("FAIL single_bright[%0d]: got %0d required %0d", i, bright,
                 exp_bright(lv[i]));
      end
      n_tests++;
      if (busy !== (i <= 10)) begin
        n_fail++;
        $display("FAIL single_busy[%0d]: got %b required %b", i, busy, (i <= 10));
      end
    end
    wait_idle("single");
  endtask

  task automatic test_fall_retrigger;
    int lv[18] = '{0, 0, 4, 8, 12, 15, 15, 15, 15, 11, 7, 7, 11, 15, 15, 15, 15, 11};
    for (int i = 0; i < 18; i++) begin
      run_cycle(i == 0 || i == 10, 1'b1);
      n_tests++;
      if (bright !== exp_bright(lv[i]) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fall_retrig[%0d]: bright=%0d busy=%b required %0d/1", i, bright, busy,
                 exp_bright(lv[i]));
      end
    end
    wait_idle("fall_retrig");
  endtask

  task automatic test_hold_retrigger;
    run_cycle(1'b1, 1'b1);
    repeat (4) run_cycle(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run_cycle(i % 2 == 0, 1'b1);
      n_tests++;
      if (bright !== exp_bright(15) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_retrig[%0d]: bright=%0d busy=%b required %0d/1", i, bright, busy,
                 exp_bright(15));
      end
    end
    // Final retrigger, then 3 hold ticks before falling.
    run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'b1);
      n_tests++;
      if (bright !== exp_bright(i < 4 ? 15 : 11)) begin
        n_fail++;
        $display("FAIL hold_release[%0d]: got %0d required %0d", i, bright,
                 exp_bright(i < 4 ? 15 : 11));
      end
    end
    wait_idle("hold_retrig");
  endtask

  task automatic test_reset_midrise;
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);
    n_tests++;
    if (bright !== exp_bright(4)) begin
      n_fail++;
      $display("FAIL midrise_pre: bright=%0d required %0d", bright, exp_bright(4));
    end
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if (bright !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrise_async: bright=%0d busy=%b required 0/0", bright, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'b1);
      n_tests++;
      if (bright !== 4'd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrise_after[%0d]: bright=%0d busy=%b required 0/0", i, bright, busy);
      end
    end
    run_cycle(1'b1, 1'b0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrise_retrig: busy=%b required 1", busy);
    end
    wait_idle("midrise");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_idle_ticks();
    test_single();
    test_fall_retrigger();
    test_hold_retrigger();
    test_reset_midrise();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
